if_id_skid_stage: RTL and testbench

Parametrised IF/ID pipeline stage with a valid/ready handshake and a two-entry skid buffer. It sits between the fetch unit and the decoder.
- Sustains one instruction per cycle when downstream is ready.
- Absorbs a downstream stall without a combinational ready path back into fetch.
- Supports a single-cycle flush for branch redirects.
- Presents a configurable NOP encoding whenever the stage holds no valid instruction.

---
 rtl/if_id_skid_stage.sv | 91 +++++++++
 tb/tb_if_id_skid_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with a two-entry skid buffer: valid/ready on both sides,
// in_ready depends only on registered state, plus a single-cycle flush for redirects.
module if_id_skid_stage #(
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        PC_W     = 64,
    parameter logic [INST_W-1:0]  NOP_INST = INST_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy
);

    logic              m_v_q, m_v_d;
    logic              s_v_q, s_v_d;
    logic [INST_W-1:0] m_inst_q, m_inst_d;
    logic [INST_W-1:0] s_inst_q, s_inst_d;
    logic [PC_W-1:0]   m_pc_q, m_pc_d;
    logic [PC_W-1:0]   s_pc_q, s_pc_d;

    logic accept;
    logic m_free;

    // Ready is taken from the skid flag only, so out_ready never reaches fetch combinationally.
    assign in_ready  = reset & ~s_v_q;
    assign accept    = in_valid & in_ready;
    assign m_free    = ~m_v_q | out_ready;

    assign out_valid = m_v_q;
    assign out_inst  = m_v_q ? m_inst_q : NOP_INST;
    assign out_pc    = m_v_q ? m_pc_q : '0;
    assign occupancy = 2'(m_v_q) + 2'(s_v_q);

    // Next-state: main register refills from skid first, then from fetch; skid absorbs one stall.
    always_comb begin
        m_v_d    = m_v_q;
        s_v_d    = s_v_q;
        m_inst_d = m_inst_q;
        m_pc_d   = m_pc_q;
        s_inst_d = s_inst_q;
        s_pc_d   = s_pc_q;
        if (flush) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (m_free) begin
            if (s_v_q) begin
                m_v_d    = 1'b1;
                m_inst_d = s_inst_q;
                m_pc_d   = s_pc_q;
                s_v_d    = 1'b0;
            end else if (accept) begin
                m_v_d    = 1'b1;
                m_inst_d = in_inst;
                m_pc_d   = in_pc;
            end else begin
                m_v_d = 1'b0;
            end
        end else if (accept) begin
            s_v_d    = 1'b1;
            s_inst_d = in_inst;
            s_pc_d   = in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_v_q    <= 1'b0;
            s_v_q    <= 1'b0;
            m_inst_q <= '0;
            m_pc_q   <= '0;
            s_inst_q <= '0;
            s_pc_q   <= '0;
        end else begin
            m_v_q    <= m_v_d;
            s_v_q    <= s_v_d;
            m_inst_q <= m_inst_d;
            m_pc_q   <= m_pc_d;
            s_inst_q <= s_inst_d;
            s_pc_q   <= s_pc_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scoreboard bench for if_id_skid_stage: default-width and 16/32-bit instances share
// stimulus; the expected held entries are an ordered queue of at most two items.
module tb_if_id_skid_stage;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    logic        clk;
    logic        reset, in_valid, flush, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        in_ready, out_valid;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic [1:0]  occupancy;

    logic        in_ready16, out_valid16;
    logic [15:0] in_inst16, out_inst16;
    logic [31:0] in_pc32, out_pc32;
    logic [1:0]  occupancy16;

    ent_t        sb_q[$];
    int          vecs = 0;
    int          errs = 0;
    bit          mon_en = 0;
    bit          acc_ok = 0;
    bit          rnd = 0;
    int          seq = 0;
    logic [31:0] cur_inst;
    logic [63:0] cur_pc;

    assign in_inst16 = in_inst[15:0];
    assign in_pc32   = in_pc[31:0];

    if_id_skid_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .occupancy(occupancy)
    );

    if_id_skid_stage #(.INST_W(16), .PC_W(32), .NOP_INST(16'h0001)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready16),
        .in_inst(in_inst16), .in_pc(in_pc32), .flush(flush), .out_valid(out_valid16),
        .out_ready(out_ready), .out_inst(out_inst16), .out_pc(out_pc32), .occupancy(occupancy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares outputs against the expected queue mid-cycle and pops on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            int   n;
            logic exp_rdy;
            n       = sb_q.size();
            exp_rdy = (reset === 1'b1) && (n < 2);
            acc_ok  = exp_rdy;
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("occupancy", 64'(occupancy), 64'(n));
            chk("out_valid", 64'(out_valid), 64'(n > 0));
            chk("in_ready16", 64'(in_ready16), 64'(exp_rdy));
            chk("occupancy16", 64'(occupancy16), 64'(n));
            chk("out_valid16", 64'(out_valid16), 64'(n > 0));
            if (n > 0) begin
                chk("out_inst", 64'(out_inst), 64'(sb_q[0].inst));
                chk("out_pc", out_pc, sb_q[0].pc);
                chk("out_inst16", 64'(out_inst16), 64'(sb_q[0].inst[15:0]));
                chk("out_pc16", 64'(out_pc32), 64'(sb_q[0].pc[31:0]));
                if (out_ready) void'(sb_q.pop_front());
            end else begin
                chk("nop_inst", 64'(out_inst), 64'h13);
                chk("nop_pc", out_pc, 64'h0);
                chk("nop_inst16", 64'(out_inst16), 64'h1);
                chk("nop_pc16", 64'(out_pc32), 64'h0);
            end
            vecs++;
            assert (!(dut.s_v_q && !dut.m_v_q) && !(dut16.s_v_q && !dut16.m_v_q))
            else begin
                errs++;
                $display("FAIL skid_implies_main: s_v set with m_v clear at %0t", $time);
            end
        end
    end

    task automatic next_data();
        if (rnd) begin
            cur_inst = $urandom;
            cur_pc   = {$urandom, $urandom};
        end else begin
            seq++;
            cur_inst = 32'h100 + 32'(seq);
            cur_pc   = 64'h1000 + 64'(4 * seq);
        end
    endtask

    // One clock: drive inputs, update the expected queue at the edge, refresh fetch data on accept.
    task automatic step(input logic iv, input logic ordy, input logic fl, input logic rs);
        bit took;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        in_inst   = cur_inst;
        in_pc     = cur_pc;
        took      = 0;
        @(posedge clk);
        if (!rs || fl) begin
            sb_q.delete();
            took = iv && fl;
        end else if (iv && acc_ok) begin
            sb_q.push_back('{inst: cur_inst, pc: cur_pc});
            took = 1;
        end
        if (took) next_data();
        #1;
    endtask

    initial begin
        cur_inst = 32'h100;
        cur_pc   = 64'h1000;
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        step(0, 0, 0, 0);
        mon_en = 1;
        step(0, 0, 0, 0);
        step(0, 1, 0, 1);

        // Streaming 0x100..0x107
        for (int k = 0; k < 8; k++) step(1, 1, 0, 1);
        step(0, 1, 0, 1);

        // Stall absorb then release
        for (int k = 0; k < 3; k++) step(1, 1, 0, 1);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 1);
        for (int k = 0; k < 4; k++) step(1, 1, 0, 1);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);

        // Flush while full, with 0xDEAD offered in the flush cycle
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        cur_inst = 32'hDEAD;
        step(1, 0, 1, 1);
        next_data();
        step(0, 1, 0, 1);
        for (int k = 0; k < 3; k++) step(1, 1, 0, 1);
        step(0, 1, 0, 1);

        // Reset mid-stall
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        step(1, 1, 0, 1);
        step(0, 1, 0, 1);

        // Random traffic
        rnd = 1;
        next_data();
        for (int k = 0; k < 10000; k++)
            step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 60),
                 1'($urandom_range(0, 99) < 5), 1'b1);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
